// File: rtl/veldt_mem_bridge.sv
// veldt_mem_bridge
//   Unified instruction/data memory for the Veldt core. It is a word-addressed
//   synchronous RAM with a read-only fetch port (pc -> word) and a data port
//   (ramIn -> ramOut) that does a read and an optional bit-masked write.
//
// Ports
//   clock   in   1   rising-edge clock
//   reset   in   1   synchronous, active-low reset
//   pc      in  32   fetch byte address
//   ramIn   in  97   {we[96], mask[95:64], addr[63:32], wdata[31:0]}
//   word    out 32   fetched instruction (registered, 1-cycle latency)
//   ramOut  out 32   load data (registered, 1-cycle latency)
//   fault   out  1   misaligned / out-of-range data access, aligned with ramOut
//   ready   out  1   memory usable
//
// Build option
//   VELDT_MEM_CLEAR_EN : when defined, a CLEAR state zeroes all DEPTH words
//   after reset, one word per cycle, before ready rises. When undefined, reset
//   goes straight to RUN and the memory contents are left untouched.
module veldt_mem_bridge #(
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [96:0] ramIn,
  output logic [31:0] word,
  output logic [31:0] ramOut,
  output logic        fault,
  output logic        ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic          d_we;
  logic [31:0]   d_mask;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [AW-1:0] d_idx;
  logic [AW-1:0] pc_idx;
  logic          d_in_range;
  logic          d_misal;
  logic          pc_in_range;

  assign d_we    = ramIn[96];
  assign d_mask  = ramIn[95:64];
  assign d_addr  = ramIn[63:32];
  assign d_wdata = ramIn[31:0];

  assign d_idx  = d_addr[AW+1:2];
  assign pc_idx = pc[AW+1:2];

  // In range means no address bit set above the word-index field.
  assign d_in_range  = ((d_addr >> (AW + 2)) == 32'd0);
  assign pc_in_range = ((pc >> (AW + 2)) == 32'd0);
  assign d_misal     = |d_addr[1:0];

  // Byte offset of the fetch address carries no meaning.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc[1:0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  logic [31:0] d_old;
  logic [31:0] d_merged;
  logic [31:0] f_old;

  assign d_old    = mem[d_idx];
  assign d_merged = (d_old & ~d_mask) | (d_wdata & d_mask);
  // Fetch reads the pre-write contents, so a same-cycle data write is not
  // visible on word until the following fetch. This also keeps ramIn out of
  // the word path entirely.
  assign f_old    = mem[pc_idx];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   ramout_q, ramout_d;
  logic          fault_q, fault_d;
  logic          ready_q, ready_d;

  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

`ifdef VELDT_MEM_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
  localparam state_e RST_STATE = S_CLEAR;
`else
  localparam state_e RST_STATE = S_RUN;
`endif

  always_comb begin
    state_d   = state_q;
    word_d    = NOP_INSN;
    ramout_d  = 32'd0;
    fault_d   = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = d_idx;
    mem_wdata = d_merged;
`ifdef VELDT_MEM_CLEAR_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
`ifdef VELDT_MEM_CLEAR_EN
      S_CLEAR: begin
        // Data-port requests are ignored; the write port belongs to the clear.
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = 32'd0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
`endif
      S_RUN: begin
        word_d = pc_in_range ? f_old : NOP_INSN;

        if (!d_in_range) begin
          fault_d  = 1'b1;
          ramout_d = 32'd0;
        end else if (d_misal) begin
          // Write suppressed; load still returns the aligned word.
          fault_d  = 1'b1;
          ramout_d = d_old;
        end else if (d_we) begin
          // Write-first: the load sees the merged value.
          mem_we   = 1'b1;
          ramout_d = d_merged;
        end else begin
          ramout_d = d_old;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase

    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      word_q   <= NOP_INSN;
      ramout_q <= 32'd0;
      fault_q  <= 1'b0;
      ready_q  <= 1'b0;
`ifdef VELDT_MEM_CLEAR_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      ramout_q <= ramout_d;
      fault_q  <= fault_d;
      ready_q  <= ready_d;
`ifdef VELDT_MEM_CLEAR_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Memory has no reset; a reset cycle simply performs no write.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign word   = word_q;
  assign ramOut = ramout_q;
  assign fault  = fault_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_veldt_mem_bridge.sv
// Self-checking bench for veldt_mem_bridge (DEPTH=16). Expected values come
// from a word-array model of the memory updated with the access rules.
module tb_veldt_mem_bridge;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = DEPTH * 4;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [96:0] ramIn;
  logic [31:0] word;
  logic [31:0] ramOut;
  logic        fault;
  logic        ready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mdl [DEPTH];

  veldt_mem_bridge #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clock  (clock),
    .reset  (reset),
    .pc     (pc),
    .ramIn  (ramIn),
    .word   (word),
    .ramOut (ramOut),
    .fault  (fault),
    .ready  (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One RUN-mode cycle: drive request, predict from the model, check outputs.
  task automatic do_req(input string tag, input logic we, input logic [31:0] mask,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pcv);
    logic [31:0] e_word, e_ram;
    logic        e_fault;
    int          wi;
    e_word = (pcv < LIMIT) ? mdl[int'(pcv >> 2)] : NOP;
    if (addr >= LIMIT) begin
      e_fault = 1'b1;
      e_ram   = 32'd0;
    end else begin
      wi = int'(addr >> 2);
      if (addr[1:0] != 2'b00) begin
        e_fault = 1'b1;
        e_ram   = mdl[wi];
      end else begin
        e_fault = 1'b0;
        if (we) mdl[wi] = (mdl[wi] & ~mask) | (wdata & mask);
        e_ram = mdl[wi];
      end
    end
    pc    = pcv;
    ramIn = {we, mask, addr, wdata};
    step();
    chk({tag, ".word"},   word,   e_word);
    chk({tag, ".ramOut"}, ramOut, e_ram);
    chk({tag, ".fault"},  {31'd0, fault}, {31'd0, e_fault});
    chk({tag, ".ready"},  {31'd0, ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".word"},   word,   NOP);
    chk({tag, ".ramOut"}, ramOut, 32'd0);
    chk({tag, ".fault"},  {31'd0, fault}, 32'd0);
    chk({tag, ".ready"},  {31'd0, ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, m, w, p, old1;
    logic        we;
    int          cyc, r;

    reset = 1'b0;
    pc    = 32'd0;
    ramIn = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;

    step();
    step();
    chk_reset_outputs("rst");

`ifdef VELDT_MEM_CLEAR_EN
    // Clear phase: ready low for exactly DEPTH cycles, NOP on word, and
    // data-port writes during the clear must be ignored.
    reset = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      pc    = 32'(($urandom % DEPTH) * 4);
      ramIn = {1'b1, 32'hFFFF_FFFF, 32'(($urandom % DEPTH) * 4), $urandom};
      step();
      chk($sformatf("clr%0d.ready", k), {31'd0, ready}, (k == DEPTH) ? 32'd1 : 32'd0);
      chk($sformatf("clr%0d.word", k), word, NOP);
      chk($sformatf("clr%0d.fault", k), {31'd0, fault}, 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
`else
    // No clear: ready on the first cycle after release; memory content is
    // unknown, so initialise it with full-mask writes before reading.
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      do_req($sformatf("init%0d", i), 1'b1, 32'hFFFF_FFFF, 32'(i * 4), $urandom, 32'h100);
    do_req("wr_then_rd.w", 1'b1, 32'hFFFF_FFFF, 32'h0000_0024, 32'hA5A5_0F0F, 32'h100);
    do_req("wr_then_rd.r", 1'b0, 32'h0,        32'h0000_0024, 32'h0,        32'h100);
    chk("wr_then_rd.direct", ramOut, 32'hA5A5_0F0F);
`endif

    // Read back every word on both ports.
    for (int i = 0; i < DEPTH; i++)
      do_req($sformatf("rdall%0d", i), 1'b0, 32'h0, 32'(i * 4), 32'h0, 32'(i * 4));

    // Masked merge.
    do_req("merge.w1", 1'b1, 32'hFFFF_FFFF, 32'h8, 32'hDEAD_BEEF, 32'h0);
    do_req("merge.w2", 1'b1, 32'h0000_FFFF, 32'h8, 32'h0000_0000, 32'h0);
    do_req("merge.r",  1'b0, 32'h0,         32'h8, 32'h0,         32'h0);
    chk("merge.direct", ramOut, 32'hDEAD_0000);
    do_req("mask0", 1'b1, 32'h0, 32'h8, 32'h1234_5678, 32'h8);

    // Misaligned write: fault pulse, no write, aligned read data.
    do_req("misal.w", 1'b1, 32'hFFFF_FFFF, 32'h6, 32'hCAFE_F00D, 32'h0);
    do_req("misal.chk", 1'b0, 32'h0, 32'h4, 32'h0, 32'h0);
    // Out of range data and fetch.
    do_req("oor.r", 1'b0, 32'h0, 32'h40, 32'h0, 32'h40);
    do_req("oor.w", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFC);
    do_req("oor.after", 1'b0, 32'h0, 32'h0, 32'h0, 32'h3C);

    // Fetch/data collision: fetch sees old value, next fetch sees new.
    old1 = mdl[1];
    do_req("coll.w", 1'b1, 32'hFFFF_FFFF, 32'h4, 32'h1234_5678, 32'h4);
    chk("coll.word_old", word, old1);
    chk("coll.ramOut", ramOut, 32'h1234_5678);
    do_req("coll.f", 1'b0, 32'h0, 32'h0, 32'h0, 32'h4);
    chk("coll.word_new", word, 32'h1234_5678);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom % 16);
      we = $urandom_range(0, 1) == 1;
      case ($urandom % 4)
        0: m = 32'h0;
        1: m = 32'hFFFF_FFFF;
        default: m = $urandom;
      endcase
      if (r < 11)      a = 32'(($urandom % DEPTH) * 4);
      else if (r < 13) a = 32'($urandom % LIMIT) | 32'd1;
      else if (r < 15) a = LIMIT + 32'($urandom % 64);
      else             a = $urandom | 32'h8000_0000;
      w = $urandom;
      p = ($urandom % 8 == 0) ? (LIMIT + 32'($urandom % 32)) : 32'($urandom % LIMIT);
      do_req($sformatf("rnd%0d", n), we, m, a, w, p);
    end

`ifdef VELDT_MEM_CLEAR_EN
    // Reset in RUN, then reset again mid-clear at cnt=7: clear restarts.
    reset = 1'b0;
    step();
    chk_reset_outputs("rst_run");
    reset = 1'b1;
    for (int k = 0; k < 7; k++) step();
    reset = 1'b0;
    step();
    chk_reset_outputs("rst_mid");
    reset = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ready) begin
        cyc = k;
        break;
      end
    end
    chk("clr_restart.cycles", 32'(cyc), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
`else
    // Reset must not disturb memory contents.
    reset = 1'b0;
    step();
    chk_reset_outputs("rst_run");
    reset = 1'b1;
`endif
    for (int i = 0; i < DEPTH; i++)
      do_req($sformatf("post%0d", i), 1'b0, 32'h0, 32'(i * 4), 32'h0, 32'((DEPTH - 1 - i) * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/veldt_mem_bridge.md
Name: veldt_mem_bridge

Overview:
- Unified instruction/data memory behind the Veldt core; directly consumes the core's `pc` and 97-bit `ramIn` bus, and produces `word` (fetched instruction) and `ramOut` (load data).
- Synchronous word-addressed RAM with two ports: fetch (read-only) and data (read plus masked write).
- Includes a post-reset clear sequencer so formal and simulation runs start from a known memory image.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- NOP_INSN, 32'h00000013, value driven on `word` while the bridge is not ready.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  32  fetch byte address from the core.
- ramIn  in  97  data request: [96] write enable; [95:64] per-bit write mask; [63:32] byte address; [31:0] write data.
- word  out  32  fetched instruction, registered.
- ramOut  out  32  load data, registered.
- fault  out  1  registered flag for a bad data access; aligned with `ramOut`.
- ready  out  1  high once memory is usable.

Behaviour:
- Reset (reset==0 sampled at a rising edge):
  - word=NOP_INSN, ramOut=0, fault=0, ready=0.
  - FSM goes to CLEAR (or RUN when clear is compiled out), clear counter = 0.
- Word index is address bits [log2(DEPTH)+1:2]. A byte address is in range when address < DEPTH*4.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt++. When cnt==DEPTH-1, the cycle after that write moves to RUN. Takes exactly DEPTH cycles.
  - RUN: normal operation. Never leaves RUN except on reset.
- Reset asserted mid-CLEAR restarts the clear from cnt=0. Reset in RUN returns to CLEAR.
- While in CLEAR:
  - ramIn writes are ignored.
  - word=NOP_INSN, ramOut=0, fault=0, ready=0.
- ready rises in the same cycle the FSM enters RUN.
- Fetch port (RUN only):
  - word <= mem[pc index]; 1-cycle latency.
  - pc[1:0] is ignored.
  - Out-of-range pc gives word=NOP_INSN.
- Data port (RUN only), every cycle:
  - Read: ramOut <= mem[addr index]; 1-cycle latency.
  - Write when we=1: mem[i] <= (mem[i] & ~mask) | (wdata & mask). mask==0 with we=1 is a no-op write.
  - Misaligned access (addr[1:0]!=0): next cycle fault=1; write suppressed; ramOut returns the aligned word.
  - Out-of-range access: next cycle fault=1; write suppressed; ramOut=0.
  - fault is a one-cycle pulse per offending request. It is not sticky.
- Data port same-cycle read/write to the same word is write-first: the next-cycle ramOut shows the merged value.
- Fetch/data collision is read-first on the fetch side. If the fetch reads the word the data port writes in the same cycle, word returns the old value; a fetch one cycle later returns the new value.
- Memory may be inferred as a two-port RAM. Merge logic must not create a combinational path from ramIn to word.

Optional Feature:
- Macro: VELDT_MEM_CLEAR_EN.
- Defined: the CLEAR state and clear counter exist as described above.
- Undefined:
  - CLEAR is removed; reset goes straight to RUN.
  - The only reset cycle drives word=NOP_INSN, ramOut=0, fault=0, ready=0.
  - ready=1 from the first cycle with reset==1.
  - Memory contents are not initialised; reset leaves them untouched.

Test Plan:
- Release reset, DEPTH=16, macro on -> ready stays 0 for exactly 16 cycles after release and word=0x00000013 throughout. Then read every address -> ramOut=0 and fault=0.
- In RUN, write addr 0x8, wdata 0xDEADBEEF, mask 0xFFFFFFFF. Then write addr 0x8, wdata 0x00000000, mask 0x0000FFFF. Then read 0x8 -> ramOut=0xDEAD0000 one cycle after the read request.
- Write addr 0x6 (misaligned) -> fault=1 for one cycle and mem[1] unchanged. Read addr 0x40 with DEPTH=16 (out of range) -> fault=1 and ramOut=0.
- Same cycle: data write of 0x12345678 to addr 0x4 and pc=0x4 -> word equals the old mem[1] value. Next cycle with pc=0x4 -> word=0x12345678. Data-port read of 0x4 in the write cycle -> ramOut=0x12345678.
- Assert reset for 1 cycle while cnt=7 in CLEAR -> the clear restarts and ready rises exactly 16 cycles after reset release.
- Macro off -> ready=1 on the first cycle after reset release. A write followed by a read on the next cycle returns the written data.
